wb_native_master: RTL
=====================

Name: wb_native_master

Overview:
- Wishbone classic single-cycle master that bridges the CPU native memory interface (valid/ready) onto the shared Wishbone bus.
- It is the initiator end that drives wb_ram and the other SoC slaves.
- Adds a bus-watchdog timeout and error termination so a missing or absent slave cannot hang the core.

Parameters:
- TIMEOUT, 255, cycles with cyc/stb asserted and no ack/err before forced termination; 0 disables the watchdog.
- ERR_DATA, 32'hDEAD_BEEF, value returned on mem_rdata for a timed-out or errored read.
- CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- wb_clk_i  in  1  system clock; all state updates on the rising edge.
- wb_rst_n_i  in  1  reset, asynchronous, active-low.
- mem_valid  in  1  CPU request; held until mem_ready.
- mem_instr  in  1  request is an instruction fetch.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte write strobes; 0 means read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data, valid while mem_ready=1.
- wb_adr_o  out  32  Wishbone address (byte address, passed through unmodified).
- wb_dat_o  out  32  Wishbone write data.
- wb_sel_o  out  4  byte selects.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_ack_i  in  1  slave acknowledge.
- wb_err_i  in  1  slave error.
- wb_dat_i  in  32  slave read data.
- mem_instr_o  out  1  registered copy of mem_instr for the current cycle (drives the slave's mem_instr).
- bus_err_o  out  1  sticky error flag (timeout or wb_err_i); cleared only by reset.
- bus_err_adr_o  out  32  address of the first failing transaction.

Behaviour:
- Reset:
  - Asynchronous, taking effect immediately regardless of state.
  - All outputs go to 0: wb_* outputs, mem_ready, mem_rdata, mem_instr_o, bus_err_o, bus_err_adr_o.
  - State returns to IDLE and the watchdog count clears.
  - Reset mid-transaction drops cyc/stb at once and produces no mem_ready.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- State machine: IDLE, BUS, DONE.
- IDLE:
  - If mem_valid=1, latch the request onto the bus outputs:
    - wb_adr_o=mem_addr, wb_dat_o=mem_wdata, mem_instr_o=mem_instr.
    - wb_we_o=|mem_wstrb.
    - wb_sel_o=mem_wstrb for a write, 4'hF for a read.
  - Assert cyc=stb=1, clear the count, and go to BUS.
  - cyc/stb therefore rise 1 cycle after mem_valid.
- BUS (cyc=stb=1, outputs stable):
  - On wb_ack_i=1 and wb_err_i=0:
    - Read: mem_rdata<=wb_dat_i.
    - Drop cyc/stb/we on the same edge, set mem_ready<=1, go to DONE.
  - On wb_err_i=1 (has priority over ack when both are high):
    - Terminate the transaction as above, but for a read mem_rdata<=ERR_DATA.
    - Set bus_err_o<=1.
    - Load bus_err_adr_o only if bus_err_o was 0.
  - Otherwise the count increments.
    - If TIMEOUT!=0 and count==TIMEOUT-1, terminate exactly as for wb_err_i.
    - Total stb-high cycles at timeout = TIMEOUT.
  - Write data is not returned; mem_rdata keeps its previous value on writes.
- DONE:
  - mem_ready is high for exactly this one cycle.
  - Next edge: mem_ready<=0, go to IDLE.
  - mem_valid is ignored in DONE, so the request just completed is never reissued.
- stb deasserts on the edge following the ack. This is the edge where wb_ram clears its own ack, so no duplicate access occurs against an ack-toggling slave.
- Minimum latency:
  - mem_valid to mem_ready is 3 cycles against a slave with 1-cycle ack (wb_ram).
  - The next request can start 1 cycle after the mem_ready cycle.
- wb_ack_i and wb_err_i are ignored outside BUS.
- Addresses are not decoded or masked; slaves do their own masking.

Test Plan:
- Read: wb_ram preloaded with mem[4]=32'h1234_5678; mem_valid, mem_addr=32'h10, wstrb=0 -> stb high 2 cycles, sel=4'hF, we=0; mem_ready one pulse with mem_rdata=32'h1234_5678; 3-cycle latency.
- Partial write then read: write 32'hAABB_CCDD with wstrb=4'b0011 to 32'h10, then read 32'h10 -> mem_rdata=32'h1234_CCDD; exactly one ack per transaction, no double write.
- Timeout: stub slave never acks, TIMEOUT=8, read to 32'h4000_0000 -> stb high 8 cycles, then mem_ready with mem_rdata=32'hDEAD_BEEF, bus_err_o=1, bus_err_adr_o=32'h4000_0000.
- Error priority and stickiness: ack and err both high on a read at 32'h20 -> mem_rdata=ERR_DATA. A second error at 32'h24 -> bus_err_adr_o stays 32'h20.
- Reset mid-transaction: assert wb_rst_n_i low while in BUS, between clock edges -> cyc/stb drop before the next edge; no mem_ready; after release, a new read completes normally.
- Back-to-back: mem_valid held continuously across 3 reads of consecutive words -> 3 distinct transactions, exactly 3 mem_ready pulses, at least one idle cycle between stb pulses.

Source files
------------

// File: rtl/wb_native_master.sv
// wb_native_master: bridges the CPU native valid/ready memory interface onto a
// classic Wishbone bus as a single-cycle master. A bus watchdog and error
// termination keep a silent or failing slave from hanging the core.
//
// Ports:
//   wb_clk_i, wb_rst_n_i       clock, async active-low reset
//   mem_valid/instr/addr/wdata/wstrb -> CPU request (wstrb==0 means read)
//   mem_ready, mem_rdata       <- one-cycle completion pulse and read data
//   wb_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o -> Wishbone request
//   wb_ack_i, wb_err_i, wb_dat_i          <- Wishbone response
//   mem_instr_o                registered instruction-fetch flag for the slave
//   bus_err_o, bus_err_adr_o   sticky error flag and first failing address
module wb_native_master #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic [31:0] wb_dat_i,
  output logic        mem_instr_o,
  output logic        bus_err_o,
  output logic [31:0] bus_err_adr_o
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  // Watchdog fires when the count reaches TIMEOUT-1, giving TIMEOUT stb-high cycles
  localparam bit               TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]  adr_q, adr_d;
  logic [DW-1:0]  dat_q, dat_d;
  logic [SW-1:0]  sel_q, sel_d;
  logic           we_q, we_d;
  logic           cyc_q, cyc_d;
  logic           ready_q, ready_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           instr_q, instr_d;
  logic           err_q, err_d;
  logic [AW-1:0]  err_adr_q, err_adr_d;

  logic           fail_c;
  logic           term_c;

  // State and output registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      instr_q   <= 1'b0;
      err_q     <= 1'b0;
      err_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      instr_q   <= instr_d;
      err_q     <= err_d;
      err_adr_q <= err_adr_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    ready_d   = 1'b0;
    rdata_d   = rdata_q;
    instr_d   = instr_q;
    err_d     = err_q;
    err_adr_d = err_adr_q;
    // err beats ack; ack beats a watchdog expiring on the same cycle
    fail_c    = 1'b0;
    term_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_valid) begin
          adr_d   = mem_addr;
          dat_d   = mem_wdata;
          instr_d = mem_instr;
          we_d    = |mem_wstrb;
          sel_d   = (|mem_wstrb) ? mem_wstrb : 4'hF;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        if (wb_err_i) begin
          fail_c = 1'b1;
          term_c = 1'b1;
        end else if (wb_ack_i) begin
          term_c = 1'b1;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          fail_c = 1'b1;
          term_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end

        if (term_c) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          ready_d = 1'b1;
          state_d = DONE;
          if (!we_q) begin
            rdata_d = fail_c ? ERR_DATA : wb_dat_i;
          end
          if (fail_c) begin
            err_d = 1'b1;
            if (!err_q) begin
              err_adr_d = adr_q;
            end
          end
        end
      end
      DONE: begin
        // mem_valid is deliberately ignored here so the finished request is not reissued
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_ready     = ready_q;
  assign mem_rdata     = rdata_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = dat_q;
  assign wb_sel_o      = sel_q;
  assign wb_we_o       = we_q;
  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;
  assign mem_instr_o   = instr_q;
  assign bus_err_o     = err_q;
  assign bus_err_adr_o = err_adr_q;

endmodule
